// File: rtl/match_referee.sv
// Two-player match referee: sequences PREP/FIGHT/ROUND_END rounds and tallies wins until a match is decided.
// Latency: all outputs are registered; a KO sampled in FIGHT is visible as round_winner/counters one cycle later.
// Backpressure: none; start is a pulse honoured only in IDLE/MATCH_OVER. Define ROUND_TIMER_EN to enable the round timer.
module match_referee #(
  parameter int ROUNDS_TO_WIN = 2,
  parameter int ROUND_TIME    = 60,
  parameter int END_HOLD      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic [3:0] p1_state,
  input  logic [3:0] p2_state,
  output logic       player_rst_n,
  output logic       fight,
  output logic [1:0] round_winner,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic       match_over,
  output logic [1:0] match_winner,
  output logic [5:0] time_left,
  output logic       error
);

  // Elaboration-time guard on the legal parameter ranges.
  if (ROUNDS_TO_WIN < 1 || ROUNDS_TO_WIN > 3) begin : g_bad_rounds
    $error("match_referee: ROUNDS_TO_WIN out of range 1..3");
  end
  if (ROUND_TIME < 1 || ROUND_TIME > 63) begin : g_bad_time
    $error("match_referee: ROUND_TIME out of range 1..63");
  end
  if (END_HOLD < 1 || END_HOLD > 15) begin : g_bad_hold
    $error("match_referee: END_HOLD out of range 1..15");
  end

  // Without the timer the countdown never runs, so time_left stays at 0.
`ifdef ROUND_TIMER_EN
  localparam logic [5:0] TIME_LOAD = 6'(ROUND_TIME);
`else
  localparam logic [5:0] TIME_LOAD = 6'd0;
`endif
  localparam logic [3:0] HOLD_LAST = 4'(END_HOLD - 1);
  localparam logic [1:0] WIN_COUNT = 2'(ROUNDS_TO_WIN);

  typedef enum logic [2:0] {
    IDLE, PREP, FIGHT, ROUND_END, MATCH_OVER
  } state_t;

  state_t     state;
  logic       prep_cnt;
  logic [3:0] hold_cnt;
  logic [1:0] verdict;

  wire [1:0] p1_place = p1_state[3:2];
  wire [1:0] p2_place = p2_state[3:2];
  wire [1:0] p1_hp    = p1_state[1:0];
  wire [1:0] p2_hp    = p2_state[1:0];
  wire       p1_ko    = (p1_hp == 2'd0);
  wire       p2_ko    = (p2_hp == 2'd0);
  wire       illegal  = (p1_place == 2'b00) || (p2_place == 2'b00) || (p1_place == p2_place);

  // Round verdict for this cycle (only acted on in FIGHT); a KO always takes priority over a timeout.
  always_comb begin
    verdict = 2'b00;
    if (p1_ko && p2_ko)  verdict = 2'b11;
    else if (p1_ko)      verdict = 2'b10;
    else if (p2_ko)      verdict = 2'b01;
`ifdef ROUND_TIMER_EN
    else if (tick && time_left == 6'd1) begin
      if (p1_hp > p2_hp)      verdict = 2'b01;
      else if (p2_hp > p1_hp) verdict = 2'b10;
      else                    verdict = 2'b11;
    end
`endif
  end

  // Referee state machine with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      prep_cnt     <= 1'b0;
      hold_cnt     <= 4'd0;
      player_rst_n <= 1'b0;
      fight        <= 1'b0;
      round_winner <= 2'b00;
      p1_rounds    <= 2'd0;
      p2_rounds    <= 2'd0;
      match_over   <= 1'b0;
      match_winner <= 2'b00;
      time_left    <= 6'd0;
      error        <= 1'b0;
    end else begin
      case (state)
        IDLE, MATCH_OVER: begin
          player_rst_n <= 1'b1;
          if (start) begin
            state        <= PREP;
            prep_cnt     <= 1'b0;
            player_rst_n <= 1'b0;
            round_winner <= 2'b00;
            time_left    <= TIME_LOAD;
            p1_rounds    <= 2'd0;
            p2_rounds    <= 2'd0;
            match_over   <= 1'b0;
            match_winner <= 2'b00;
            error        <= 1'b0;
          end
        end
        PREP: begin
          // Player reset is held low for this cycle and the next, then the round goes live.
          prep_cnt <= 1'b1;
          if (prep_cnt) begin
            state        <= FIGHT;
            player_rst_n <= 1'b1;
            fight        <= 1'b1;
          end
        end
        FIGHT: begin
          if (illegal) error <= 1'b1;
`ifdef ROUND_TIMER_EN
          if (tick && !p1_ko && !p2_ko) time_left <= time_left - 6'd1;
`endif
          if (verdict != 2'b00) begin
            state        <= ROUND_END;
            fight        <= 1'b0;
            hold_cnt     <= 4'd0;
            round_winner <= verdict;
            if (verdict == 2'b01 && p1_rounds != 2'd3) p1_rounds <= p1_rounds + 2'd1;
            if (verdict == 2'b10 && p2_rounds != 2'd3) p2_rounds <= p2_rounds + 2'd1;
          end
        end
        ROUND_END: begin
          if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              if (p1_rounds == WIN_COUNT) begin
                state        <= MATCH_OVER;
                match_over   <= 1'b1;
                match_winner <= 2'b01;
              end else if (p2_rounds == WIN_COUNT) begin
                state        <= MATCH_OVER;
                match_over   <= 1'b1;
                match_winner <= 2'b10;
              end else begin
                state        <= PREP;
                prep_cnt     <= 1'b0;
                player_rst_n <= 1'b0;
                round_winner <= 2'b00;
                time_left    <= TIME_LOAD;
              end
            end else begin
              hold_cnt <= hold_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_referee.sv
// Directed bench for match_referee: rounds, match win, draw, errors, timer and mid-round reset.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Expected values are hand-derived constants; the timer build is selected by ROUND_TIMER_EN.
module tb_match_referee;

`ifdef ROUND_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif
  localparam logic [5:0] TLOAD = TIMER ? 6'd4 : 6'd0;
  localparam logic [3:0] P1_OK = 4'b1011;   // place 10, health 3
  localparam logic [3:0] P2_OK = 4'b0111;   // place 01, health 3

  logic       clk = 1'b0;
  logic       reset, start, tick;
  logic [3:0] p1_state, p2_state;
  logic       player_rst_n, fight, match_over, error;
  logic [1:0] round_winner, p1_rounds, p2_rounds, match_winner;
  logic [5:0] time_left;
  int         total = 0;
  int         bad = 0;

  match_referee #(.ROUNDS_TO_WIN(2), .ROUND_TIME(4), .END_HOLD(3)) dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick),
    .p1_state(p1_state), .p2_state(p2_state),
    .player_rst_n(player_rst_n), .fight(fight), .round_winner(round_winner),
    .p1_rounds(p1_rounds), .p2_rounds(p2_rounds), .match_over(match_over),
    .match_winner(match_winner), .time_left(time_left), .error(error)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_tick;
    tick = 1'b1; cyc(1); tick = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; tick = 1'b0; p1_state = P1_OK; p2_state = P2_OK;
    #12;
    total++; if ({player_rst_n, fight, round_winner, p1_rounds, p2_rounds, match_over, match_winner, time_left, error} !== 18'd0) begin bad++; $display("FAIL reset_vals got %b want 0", {player_rst_n, fight, round_winner, p1_rounds, p2_rounds, match_over, match_winner, time_left, error}); end
    reset = 1'b1;
    cyc(1);
    total++; if (player_rst_n !== 1'b1) begin bad++; $display("FAIL rst_release player_rst_n got %b want 1", player_rst_n); end
    total++; if (fight !== 1'b0) begin bad++; $display("FAIL idle_fight got %b want 0", fight); end
  endtask

  task automatic test_p1_ko_round;
    start = 1'b1; cyc(1); start = 1'b0; p2_state = 4'b0000;
    total++; if (player_rst_n !== 1'b0) begin bad++; $display("FAIL prep_c1 player_rst_n got %b want 0", player_rst_n); end
    cyc(1); p2_state = P2_OK;
    total++; if ({player_rst_n, fight, error} !== 3'b000) begin bad++; $display("FAIL prep_c2 rst/fight/err got %b want 000", {player_rst_n, fight, error}); end
    cyc(1);
    total++; if ({player_rst_n, fight} !== 2'b11) begin bad++; $display("FAIL fight_entry rst/fight got %b want 11", {player_rst_n, fight}); end
    total++; if (time_left !== TLOAD) begin bad++; $display("FAIL time_load got %0d want %0d", time_left, TLOAD); end
    p2_state = 4'b0100; cyc(1);
    total++; if ({round_winner, p1_rounds, p2_rounds, fight} !== 7'b01_01_00_0) begin bad++; $display("FAIL p2_ko rw/p1/p2/fight got %b want 0101000", {round_winner, p1_rounds, p2_rounds, fight}); end
    do_tick; do_tick;
    total++; if ({player_rst_n, fight, round_winner} !== 4'b1001) begin bad++; $display("FAIL end_hold rst/fight/rw got %b want 1001", {player_rst_n, fight, round_winner}); end
    do_tick;
    total++; if ({player_rst_n, round_winner} !== 3'b000) begin bad++; $display("FAIL reprep rst/rw got %b want 000", {player_rst_n, round_winner}); end
    p2_state = P2_OK; cyc(1);
    total++; if (player_rst_n !== 1'b0) begin bad++; $display("FAIL reprep_c2 player_rst_n got %b want 0", player_rst_n); end
    cyc(1);
    total++; if ({player_rst_n, fight, p1_rounds} !== 4'b11_01) begin bad++; $display("FAIL round2 rst/fight/p1 got %b want 1101", {player_rst_n, fight, p1_rounds}); end
  endtask

  task automatic test_match_win;
    p2_state = 4'b0100; cyc(1); p2_state = P2_OK;
    total++; if ({p1_rounds, round_winner, match_over} !== 5'b10_01_0) begin bad++; $display("FAIL second_ko p1/rw/mo got %b want 10010", {p1_rounds, round_winner, match_over}); end
    do_tick; do_tick; do_tick;
    total++; if ({match_over, match_winner, fight, player_rst_n} !== 5'b1_01_0_1) begin bad++; $display("FAIL match_over mo/mw/fight/rst got %b want 10101", {match_over, match_winner, fight, player_rst_n}); end
    cyc(3);
    total++; if ({match_over, match_winner, round_winner, p1_rounds} !== 7'b1_01_01_10) begin bad++; $display("FAIL match_hold got %b want 1010110", {match_over, match_winner, round_winner, p1_rounds}); end
    start = 1'b1; cyc(1); start = 1'b0;
    total++; if ({p1_rounds, p2_rounds, match_over, match_winner, player_rst_n, round_winner} !== 10'd0) begin bad++; $display("FAIL restart got %b want 0", {p1_rounds, p2_rounds, match_over, match_winner, player_rst_n, round_winner}); end
    cyc(2);
    total++; if (fight !== 1'b1) begin bad++; $display("FAIL restart_fight got %b want 1", fight); end
  endtask

  task automatic test_draw_and_p2;
    start = 1'b1; cyc(1); start = 1'b0;
    total++; if ({player_rst_n, fight} !== 2'b11) begin bad++; $display("FAIL start_ign_fight got %b want 11", {player_rst_n, fight}); end
    p1_state = 4'b0100; p2_state = 4'b1100; tick = 1'b1; cyc(1); tick = 1'b0;
    p1_state = P1_OK; p2_state = P2_OK;
    total++; if ({round_winner, p1_rounds, p2_rounds, fight, error} !== 8'b11_00_00_0_0) begin bad++; $display("FAIL draw got %b want 11000000", {round_winner, p1_rounds, p2_rounds, fight, error}); end
    total++; if (time_left !== TLOAD) begin bad++; $display("FAIL ko_tick time_left got %0d want %0d", time_left, TLOAD); end
    start = 1'b1; cyc(1); start = 1'b0;
    total++; if ({fight, player_rst_n, round_winner} !== 4'b0111) begin bad++; $display("FAIL start_ign_end got %b want 0111", {fight, player_rst_n, round_winner}); end
    do_tick; do_tick; do_tick;
    total++; if ({player_rst_n, match_over} !== 2'b00) begin bad++; $display("FAIL draw_next got %b want 00", {player_rst_n, match_over}); end
    cyc(2);
    p1_state = 4'b1000; cyc(1); p1_state = P1_OK;
    total++; if ({round_winner, p1_rounds, p2_rounds, error} !== 7'b10_00_01_0) begin bad++; $display("FAIL p1_ko got %b want 1000010", {round_winner, p1_rounds, p2_rounds, error}); end
    do_tick; do_tick; do_tick; cyc(2);
    total++; if (fight !== 1'b1) begin bad++; $display("FAIL round_after_p2 fight got %b want 1", fight); end
  endtask

  task automatic test_error;
    p2_state = 4'b1011; cyc(1); p2_state = P2_OK;
    total++; if ({error, fight} !== 2'b11) begin bad++; $display("FAIL err_set err/fight got %b want 11", {error, fight}); end
    cyc(2);
    total++; if ({error, fight} !== 2'b11) begin bad++; $display("FAIL err_sticky err/fight got %b want 11", {error, fight}); end
    p2_state = 4'b0100; cyc(1); p2_state = P2_OK;
    total++; if ({p1_rounds, round_winner, error} !== 5'b01_01_1) begin bad++; $display("FAIL err_ko got %b want 01011", {p1_rounds, round_winner, error}); end
    do_tick; do_tick; do_tick; cyc(2);
    total++; if ({fight, error} !== 2'b11) begin bad++; $display("FAIL err_next_round got %b want 11", {fight, error}); end
    p2_state = 4'b0100; cyc(1); p2_state = P2_OK;
    do_tick; do_tick; do_tick;
    total++; if ({match_over, match_winner, p1_rounds, p2_rounds, error} !== 8'b1_01_10_01_1) begin bad++; $display("FAIL err_match got %b want 10110011", {match_over, match_winner, p1_rounds, p2_rounds, error}); end
    start = 1'b1; cyc(1); start = 1'b0;
    total++; if ({error, p1_rounds, p2_rounds, match_winner} !== 7'd0) begin bad++; $display("FAIL err_clear got %b want 0", {error, p1_rounds, p2_rounds, match_winner}); end
    cyc(2);
  endtask

  task automatic test_timer;
    p1_state = 4'b1010; p2_state = 4'b0101;
    do_tick; do_tick; do_tick;
    total++; if ({fight, time_left} !== {1'b1, (TIMER ? 6'd1 : 6'd0)}) begin bad++; $display("FAIL timer_count fight/time got %b/%0d want 1/%0d", fight, time_left, TIMER ? 1 : 0); end
    do_tick;
    total++; if ({fight, round_winner, time_left} !== (TIMER ? 9'b0_01_000000 : 9'b1_00_000000)) begin bad++; $display("FAIL timer_end fight/rw/time got %b want %b", {fight, round_winner, time_left}, (TIMER ? 9'b0_01_000000 : 9'b1_00_000000)); end
    if (!TIMER) begin p2_state = 4'b0100; cyc(1); end
    p1_state = P1_OK; p2_state = P2_OK;
    total++; if ({p1_rounds, p2_rounds} !== 4'b01_00) begin bad++; $display("FAIL timer_rounds got %b want 0100", {p1_rounds, p2_rounds}); end
    do_tick; do_tick; do_tick; cyc(2);
    total++; if ({fight, p1_rounds} !== 3'b1_01) begin bad++; $display("FAIL timer_next got %b want 101", {fight, p1_rounds}); end
  endtask

  task automatic test_reset_mid_fight;
    #2; reset = 1'b0; #1;
    total++; if ({player_rst_n, fight, round_winner, p1_rounds, p2_rounds, match_over, match_winner, time_left, error} !== 18'd0) begin bad++; $display("FAIL midreset_vals got %b want 0", {player_rst_n, fight, round_winner, p1_rounds, p2_rounds, match_over, match_winner, time_left, error}); end
    cyc(1);
    total++; if ({player_rst_n, p1_rounds} !== 3'b0) begin bad++; $display("FAIL midreset_held got %b want 000", {player_rst_n, p1_rounds}); end
    reset = 1'b1; cyc(1);
    total++; if ({player_rst_n, fight, p1_rounds} !== 4'b1_0_00) begin bad++; $display("FAIL midreset_release got %b want 1000", {player_rst_n, fight, p1_rounds}); end
    do_tick; cyc(2);
    total++; if ({fight, player_rst_n, round_winner} !== 4'b0100) begin bad++; $display("FAIL midreset_idle got %b want 0100", {fight, player_rst_n, round_winner}); end
    start = 1'b1; cyc(1); start = 1'b0;
    total++; if (player_rst_n !== 1'b0) begin bad++; $display("FAIL idle_start player_rst_n got %b want 0", player_rst_n); end
  endtask

  initial begin
    test_reset;
    test_p1_ko_round;
    test_match_win;
    test_draw_and_p2;
    test_error;
    test_timer;
    test_reset_mid_fight;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/match_referee.md
MATCH_REFEREE -- requirements
Module: match_referee

Interface
REQ-001 Parameter ROUNDS_TO_WIN, default 2: round wins needed to take the match; legal range 1..3.
REQ-002 Parameter ROUND_TIME, default 60: round length in tick pulses; legal range 1..63.
REQ-003 Parameter END_HOLD, default 3: tick pulses spent in ROUND_END before continuing; legal range 1..15.
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 reset  input  1  asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse; begins a match.
REQ-007 tick  input  1  one-cycle timebase enable.
REQ-008 p1_state  input  4  player-1 FSM output, {place[1:0], health[1:0]}; place 01/10/11 legal, 00 illegal.
REQ-009 p2_state  input  4  player-2 FSM output, same encoding.
REQ-010 player_rst_n  output  1  active-low reset to both player FSMs.
REQ-011 fight  output  1  high while a round is live.
REQ-012 round_winner  output  2  00 none, 01 P1, 10 P2, 11 draw.
REQ-013 p1_rounds, p2_rounds  output  2 each  rounds won this match.
REQ-014 match_over  output  1  match decided.
REQ-015 match_winner  output  2  01 P1, 10 P2, 00 undecided.
REQ-016 time_left  output  6  remaining round ticks.
REQ-017 error  output  1  sticky illegal-state flag.

Function
REQ-018 The FSM SHALL have the states IDLE, PREP, FIGHT, ROUND_END and MATCH_OVER.
REQ-019 IDLE: start SHALL go to PREP and clear p1_rounds, p2_rounds, match_winner and error.
REQ-020 PREP: player_rst_n SHALL be held low for exactly 2 cycles; round_winner SHALL be cleared to 00; time_left SHALL be loaded with ROUND_TIME; the FSM SHALL then enter FIGHT.
REQ-021 FIGHT: fight=1, and health SHALL be sampled every cycle.
REQ-022 FIGHT, both health==0 in the same cycle: round_winner SHALL be 11 (draw).
REQ-023 FIGHT, only P1 health==0: round_winner SHALL be 10; only P2 health==0: round_winner SHALL be 01.
REQ-024 On any round decision the FSM SHALL enter ROUND_END in the next cycle.
REQ-025 On entry to ROUND_END the winner's counter SHALL increment by 1; a draw SHALL increment neither counter; counters SHALL saturate at 3.
REQ-026 ROUND_END: fight=0; the state SHALL persist for END_HOLD tick pulses.
REQ-027 On leaving ROUND_END: if either counter equals ROUNDS_TO_WIN the FSM SHALL go to MATCH_OVER and set match_winner accordingly; otherwise it SHALL go to PREP.
REQ-028 MATCH_OVER: match_over=1 and all outputs SHALL hold; start SHALL behave as in IDLE (REQ-019).
REQ-029 start SHALL be ignored in PREP, FIGHT and ROUND_END.
REQ-030 In FIGHT, a place field of 00 in either player state, or p1 place == p2 place, SHALL set error; error SHALL stay set until start is accepted or reset asserts; the round SHALL continue.
REQ-031 A KO and a tick in the same cycle: the KO SHALL win, and time_left SHALL NOT decrement.
REQ-032 Player states SHALL be ignored outside FIGHT, including during the PREP reset window.

Reset
REQ-033 reset low SHALL force IDLE asynchronously.
REQ-034 Reset values: player_rst_n=0, fight=0, round_winner=00, p1_rounds=p2_rounds=0, match_over=0, match_winner=00, time_left=0, error=0.
REQ-035 player_rst_n SHALL deassert on the first clk edge after reset releases.
REQ-036 Reset asserted mid-round SHALL abandon the match; no counter update SHALL occur.

Configuration
REQ-037 With macro ROUND_TIMER_EN defined, each tick in FIGHT SHALL decrement time_left.
REQ-038 With ROUND_TIMER_EN defined, time_left reaching 0 SHALL decide the round: higher health wins; equal health is a draw (11).
REQ-039 Without ROUND_TIMER_EN, time_left SHALL be constant 0, tick SHALL affect only ROUND_END, and rounds SHALL end only by KO.

Verification
REQ-040 Bench SHALL cover: start; p2_state 0100 in FIGHT -> round_winner 01, p1_rounds 1, after 3 ticks PREP with player_rst_n low 2 cycles.
REQ-041 Bench SHALL cover: P1 wins two rounds (ROUNDS_TO_WIN=2) -> match_over 1, match_winner 01; start -> counters 0, PREP.
REQ-042 Bench SHALL cover: p1_state 0100 and p2_state 1100 in the same cycle -> round_winner 11, both counters unchanged.
REQ-043 Bench SHALL cover (ROUND_TIMER_EN, ROUND_TIME=4): 4 ticks with P1 health 2 and P2 health 1 -> time_left 0, round_winner 01; same run without the macro -> no decision.
REQ-044 Bench SHALL cover: both places 10 in FIGHT -> error 1 held through the next round, cleared by start after MATCH_OVER.
REQ-045 Bench SHALL cover: reset pulsed low mid-FIGHT with p1_rounds 1 -> all outputs at reset values, IDLE.
